com_stroke_tracker: RTL and testbench
=====================================

# com_stroke_tracker

Consumes the center-of-mass sample stream from the camera front end (new_com, light_on, x_com, y_com), debounces the light state into pen-down/pen-up strokes, and emits line-segment requests (x0,y0)->(x1,y1) to the line-drawing engine over a valid/ready handshake. It sits between camera center-of-mass detection and the framebuffer draw path.

## Interface
- X_MAX, 1279: largest legal x; larger x_com is clamped to X_MAX.
- Y_MAX, 719: largest legal y; larger y_com is clamped to Y_MAX.
- ON_DEBOUNCE, 3: consecutive light-on samples required to start a stroke (1..15).
- OFF_DEBOUNCE, 4: consecutive light-off samples required to end a stroke (1..15).
- MIN_STEP, 2: minimum Manhattan distance |dx|+|dy| from the anchor before a segment is emitted.
- SMOOTH_SHIFT, 2: EMA shift, used only when smoothing is compiled in (0..4).

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-high.
- new_com  in  1  qualifies a sample; every cycle it is high is one sample.
- light_on  in  1  light detected in this sample.
- x_com  in  11  sample x.
- y_com  in  10  sample y.
- seg_valid  out  1  segment available.
- seg_ready  in  1  consumer accepts when seg_valid && seg_ready.
- seg_x0, seg_x1  out  11  segment endpoints x.
- seg_y0, seg_y1  out  10  segment endpoints y.
- pen_down  out  1  high in DRAWING or RELEASING.

## Operation
- Stage 1 (sample register): clamp x/y, filter (see Configuration), and register the point plus light_on and a sample strobe.
- FSM on stage-1 strobes:
  - IDLE: a light-on sample sets cnt=1. When ON_DEBOUNCE==1, go directly to DRAWING; otherwise go to ARMING.
  - ARMING: a light-on sample increments cnt, and reaching ON_DEBOUNCE goes to DRAWING. A light-off sample returns to IDLE with cnt=0.
  - Entry to DRAWING: anchor := current filtered point; no segment is emitted.
  - DRAWING: a light-on sample is evaluated for a segment. A light-off sample sets cnt=1 and goes to RELEASING, or goes to IDLE when OFF_DEBOUNCE==1.
  - RELEASING: a light-off sample increments cnt, and reaching OFF_DEBOUNCE goes to IDLE. A light-on sample returns to DRAWING, clears cnt, and is evaluated for a segment.
- Positions of light-off samples are ignored and do not update the filter.
- Segment evaluation: let d = |fx-ax|+|fy-ay| (12-bit unsigned). If d >= MIN_STEP and the output slot is free (or being accepted this cycle), then load seg := (ax,ay,fx,fy), set seg_valid, and set anchor := (fx,fy). Otherwise the anchor is held, so the next emitted segment still starts at the old anchor and continuity is preserved (no gaps).
- The output slot holds one entry. seg_* outputs stay stable while seg_valid && !seg_ready.
- Simultaneous accept and load in the same cycle: the new segment replaces the old one, and seg_valid stays high.
- Pen-up emits no tail segment. A pending segment remains valid across pen-up until it is accepted.
- An illegal (out-of-range) coordinate is clamped, never dropped.

## Timing
- A qualifying sample at cycle t produces its segment at cycle t+2 (seg_valid high from t+2).
- pen_down updates at t+2 on the sample that completes the debounce count.
- Back-to-back samples every cycle are supported at full rate.
- Reset values: seg_valid=0, seg_x0/x1/y0/y1=0, pen_down=0, FSM=IDLE, cnt=0, anchor=(0,0), filter=(0,0).
- rst_in mid-stroke clears state immediately and asynchronously; a pending segment is discarded.

## Configuration
- COM_SMOOTH_EN defined:
  - The filtered point is f += (s - f) >>> SMOOTH_SHIFT, using 12-bit signed differences and a result clamped to [0, MAX].
  - The first light-on sample in IDLE loads f := s directly.
- COM_SMOOTH_EN undefined: f := clamped sample, and SMOOTH_SHIFT is unused.

## Structure
- Shared package com_pkg:
  - Coordinate typedefs xcoord_t (11 bits) and ycoord_t (10 bits).
  - A segment_t struct {x0, y0, x1, y1}.
  - The tracker state enum {IDLE, ARMING, DRAWING, RELEASING}.
  - Default X_MAX and Y_MAX constants.
- Sub-module com_filter: clamp plus optional EMA. It is one instance, purely registered, one cycle.

## Test plan
- Reset with seg_ready=1: feed 3 light-on samples at (100,100), then 1 at (110,100). Expect pen_down to rise after the 3rd sample and one segment (100,100)->(110,100) at t+2.
- Debounce: light-on samples at on,on,off,on,on. Expect pen_down to stay 0 and no segment.
- Backpressure: while drawing, hold seg_ready=0 and feed (120,100) then (130,100). Expect a single held segment (110,100)->(120,100). After release, the next sample at (140,100) yields (120,100)->(140,100).
- Small step: while drawing with the anchor at (50,50), feed (51,50). Expect no segment. Then feed (51,51) (d=2). Expect segment (50,50)->(51,51).
- Clamp and pen-up: feed x_com=2000. Expect x1=1279. Then 4 light-off samples. Expect pen_down=0 and no extra segment. Assert rst_in mid-stroke and expect seg_valid=0 immediately.
- With COM_SMOOTH_EN and SMOOTH_SHIFT=2: start a stroke at (0,0), then feed (100,0). Expect filtered x=25 and segment (0,0)->(25,0).

Source files
------------

// File: rtl/com_pkg.sv
// Shared types and defaults for the center-of-mass stroke tracker.
package com_pkg;

  localparam int unsigned X_W       = 11;
  localparam int unsigned Y_W       = 10;
  localparam int unsigned D_W       = 12;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned X_MAX_DEF = 1279;
  localparam int unsigned Y_MAX_DEF = 719;

  typedef logic [X_W-1:0] xcoord_t;
  typedef logic [Y_W-1:0] ycoord_t;

  typedef struct packed {
    xcoord_t x0;
    ycoord_t y0;
    xcoord_t x1;
    ycoord_t y1;
  } segment_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    DRAWING,
    RELEASING
  } trk_state_t;

endpackage

// File: rtl/com_filter.sv
// Stage-1 sample register: clamp to the legal frame, optional EMA smoothing.
// Optional feature: COM_SMOOTH_EN enables the EMA filter.
import com_pkg::*;

module com_filter #(
  parameter int unsigned X_MAX        = X_MAX_DEF,
  parameter int unsigned Y_MAX        = Y_MAX_DEF,
  parameter int unsigned SMOOTH_SHIFT = 2
) (
  input  logic    clk_in,
  input  logic    rst_in,
  input  logic    sample_valid,
  input  logic    light_on,
  input  logic    load_direct,
  input  xcoord_t x_com,
  input  ycoord_t y_com,
  output logic    pt_valid,
  output logic    pt_light,
  output xcoord_t fx,
  output ycoord_t fy
);

  xcoord_t sx_c, nx_c;
  ycoord_t sy_c, ny_c;

  assign sx_c = (x_com > X_W'(X_MAX)) ? X_W'(X_MAX) : x_com;
  assign sy_c = (y_com > Y_W'(Y_MAX)) ? Y_W'(Y_MAX) : y_com;

`ifdef COM_SMOOTH_EN
  logic signed [11:0] dx_c, dy_c, dxs_c, dys_c;
  logic signed [12:0] ex_c, ey_c;

  // f += (s - f) >>> SMOOTH_SHIFT, clamped back into [0, MAX]
  assign dx_c  = $signed({1'b0, sx_c}) - $signed({1'b0, fx});
  assign dy_c  = $signed({2'b0, sy_c}) - $signed({2'b0, fy});
  assign dxs_c = dx_c >>> SMOOTH_SHIFT;
  assign dys_c = dy_c >>> SMOOTH_SHIFT;
  assign ex_c  = $signed({2'b0, fx}) + $signed({dxs_c[11], dxs_c});
  assign ey_c  = $signed({3'b0, fy}) + $signed({dys_c[11], dys_c});

  always_comb begin
    nx_c = sx_c;
    ny_c = sy_c;
    if (!load_direct) begin
      nx_c = ex_c[12] ? '0 : (ex_c[11:0] > 12'(X_MAX)) ? X_W'(X_MAX) : ex_c[X_W-1:0];
      ny_c = ey_c[12] ? '0 : (ey_c[11:0] > 12'(Y_MAX)) ? Y_W'(Y_MAX) : ey_c[Y_W-1:0];
    end
  end
`else
  logic [3:0] unused_cfg;
  assign unused_cfg = {load_direct, 3'(SMOOTH_SHIFT)};
  assign nx_c = sx_c;
  assign ny_c = sy_c;
`endif

  // light-off samples pass their strobe through but never touch the filter
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pt_valid <= 1'b0;
      pt_light <= 1'b0;
      fx       <= '0;
      fy       <= '0;
    end else begin
      pt_valid <= sample_valid;
      pt_light <= light_on;
      if (sample_valid && light_on) begin
        fx <= nx_c;
        fy <= ny_c;
      end
    end
  end

endmodule

// File: rtl/com_stroke_tracker.sv
// Debounces light state into strokes and emits line segments over valid/ready.
// Optional feature: COM_SMOOTH_EN enables EMA smoothing in com_filter.
import com_pkg::*;

module com_stroke_tracker #(
  parameter int unsigned X_MAX        = X_MAX_DEF,
  parameter int unsigned Y_MAX        = Y_MAX_DEF,
  parameter int unsigned ON_DEBOUNCE  = 3,
  parameter int unsigned OFF_DEBOUNCE = 4,
  parameter int unsigned MIN_STEP     = 2,
  parameter int unsigned SMOOTH_SHIFT = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        new_com,
  input  logic        light_on,
  input  logic [10:0] x_com,
  input  logic [9:0]  y_com,
  output logic        seg_valid,
  input  logic        seg_ready,
  output logic [10:0] seg_x0,
  output logic [9:0]  seg_y0,
  output logic [10:0] seg_x1,
  output logic [9:0]  seg_y1,
  output logic        pen_down
);

  trk_state_t state;
  logic [CNT_W-1:0] cnt, cnt_inc_c;
  logic    pt_valid, pt_light, will_idle_c, emit_c;
  xcoord_t fx, ax, adx_c;
  ycoord_t fy, ay, ady_c;
  logic [D_W-1:0] d_c;
  segment_t seg_q;

  com_filter #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .SMOOTH_SHIFT(SMOOTH_SHIFT)
  ) u_filter (
    .clk_in(clk_in), .rst_in(rst_in), .sample_valid(new_com), .light_on(light_on),
    .load_direct(will_idle_c), .x_com(x_com), .y_com(y_com),
    .pt_valid(pt_valid), .pt_light(pt_light), .fx(fx), .fy(fy)
  );

  assign cnt_inc_c = cnt + CNT_W'(1);
  assign adx_c     = (fx >= ax) ? fx - ax : ax - fx;
  assign ady_c     = (fy >= ay) ? fy - ay : ay - fy;
  assign d_c       = D_W'(adx_c) + D_W'(ady_c);
  assign emit_c    = pt_valid && pt_light && (state == DRAWING || state == RELEASING) &&
                     (d_c >= D_W'(MIN_STEP)) && (!seg_valid || seg_ready);

  // Tracker state the next stage-1 sample will see; tells the filter to load directly
  always_comb begin
    will_idle_c = (state == IDLE);
    if (pt_valid) begin
      if (pt_light) begin
        will_idle_c = 1'b0;
      end else begin
        case (state)
          IDLE, ARMING: will_idle_c = 1'b1;
          DRAWING:      will_idle_c = (OFF_DEBOUNCE == 1);
          RELEASING:    will_idle_c = (cnt_inc_c >= CNT_W'(OFF_DEBOUNCE));
          default:      will_idle_c = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      cnt       <= '0;
      ax        <= '0;
      ay        <= '0;
      pen_down  <= 1'b0;
      seg_valid <= 1'b0;
      seg_q     <= '0;
    end else begin
      if (seg_valid && seg_ready) seg_valid <= 1'b0;
      if (pt_valid) begin
        case (state)
          IDLE: if (pt_light) begin
            if (ON_DEBOUNCE == 1) begin
              state    <= DRAWING;
              pen_down <= 1'b1;
              cnt      <= '0;
              ax       <= fx;
              ay       <= fy;
            end else begin
              state <= ARMING;
              cnt   <= CNT_W'(1);
            end
          end
          ARMING: if (!pt_light) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt_inc_c >= CNT_W'(ON_DEBOUNCE)) begin
            state    <= DRAWING;
            pen_down <= 1'b1;
            cnt      <= '0;
            ax       <= fx;
            ay       <= fy;
          end else begin
            cnt <= cnt_inc_c;
          end
          DRAWING: if (!pt_light) begin
            if (OFF_DEBOUNCE == 1) begin
              state    <= IDLE;
              pen_down <= 1'b0;
              cnt      <= '0;
            end else begin
              state <= RELEASING;
              cnt   <= CNT_W'(1);
            end
          end
          RELEASING: if (pt_light) begin
            state <= DRAWING;
            cnt   <= '0;
          end else if (cnt_inc_c >= CNT_W'(OFF_DEBOUNCE)) begin
            state    <= IDLE;
            pen_down <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt_inc_c;
          end
          default: state <= IDLE;
        endcase
      end
      // a load overrides the accept-clear, so accept+load keeps seg_valid high
      if (emit_c) begin
        seg_q     <= '{x0: ax, y0: ay, x1: fx, y1: fy};
        seg_valid <= 1'b1;
        ax        <= fx;
        ay        <= fy;
      end
    end
  end

  assign seg_x0 = seg_q.x0;
  assign seg_y0 = seg_q.y0;
  assign seg_x1 = seg_q.x1;
  assign seg_y1 = seg_q.y1;

endmodule

// File: tb/tb_com_stroke_tracker.sv
// Directed self-checking bench for com_stroke_tracker (default params; COM_SMOOTH_EN selects the EMA case).
module tb_com_stroke_tracker;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        new_com, light_on, seg_ready;
  logic [10:0] x_com;
  logic [9:0]  y_com;
  logic        seg_valid, pen_down;
  logic [10:0] seg_x0, seg_x1;
  logic [9:0]  seg_y0, seg_y1;

  int n_tests = 0;
  int n_fail  = 0;

  com_stroke_tracker dut (
    .clk_in(clk_in), .rst_in(rst_in), .new_com(new_com), .light_on(light_on),
    .x_com(x_com), .y_com(y_com), .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_x0(seg_x0), .seg_y0(seg_y0), .seg_x1(seg_x1), .seg_y1(seg_y1),
    .pen_down(pen_down)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // One sample presented across one rising edge; returns on the following falling edge
  task automatic send(input logic lo, input int x, input int y);
    @(negedge clk_in);
    new_com  = 1'b1;
    light_on = lo;
    x_com    = 11'(x);
    y_com    = 10'(y);
    @(negedge clk_in);
    new_com  = 1'b0;
    light_on = 1'b0;
  endtask

  task automatic check_seg(input string tag, input int x0, input int y0, input int x1, input int y1);
    check({tag, ".valid"}, int'(seg_valid), 1);
    check({tag, ".x0"}, int'(seg_x0), x0);
    check({tag, ".y0"}, int'(seg_y0), y0);
    check({tag, ".x1"}, int'(seg_x1), x1);
    check({tag, ".y1"}, int'(seg_y1), y1);
  endtask

  initial begin
    rst_in = 1'b1; new_com = 1'b0; light_on = 1'b0;
    x_com = '0; y_com = '0; seg_ready = 1'b1;
    repeat (2) @(negedge clk_in);
    check("rst.valid", int'(seg_valid), 0);
    check("rst.x0", int'(seg_x0), 0);
    check("rst.y1", int'(seg_y1), 0);
    check("rst.pen", int'(pen_down), 0);
    rst_in = 1'b0;

`ifdef COM_SMOOTH_EN
    repeat (3) send(1'b1, 0, 0);
    send(1'b1, 100, 0);
    @(negedge clk_in);
    check_seg("ema1", 0, 0, 25, 0);
    send(1'b1, 100, 0);
    @(negedge clk_in);
    check_seg("ema2", 25, 0, 43, 0);
`else
    // debounce: interrupted run never reaches pen-down
    send(1'b1, 100, 100); send(1'b1, 100, 100); send(1'b0, 0, 0);
    send(1'b1, 100, 100); send(1'b1, 100, 100); send(1'b0, 0, 0);
    repeat (2) @(negedge clk_in);
    check("deb.pen", int'(pen_down), 0);
    check("deb.valid", int'(seg_valid), 0);

    // stroke start and first-segment latency
    repeat (3) send(1'b1, 100, 100);
    check("start.pen_early", int'(pen_down), 0);
    @(negedge clk_in);
    check("start.pen", int'(pen_down), 1);
    check("start.noseg", int'(seg_valid), 0);
    send(1'b1, 110, 100);
    check("seg1.latency", int'(seg_valid), 0);
    @(negedge clk_in);
    check_seg("seg1", 100, 100, 110, 100);
    @(negedge clk_in);
    check("seg1.accepted", int'(seg_valid), 0);

    // backpressure: second segment is held off, anchor stays at 120
    seg_ready = 1'b0;
    send(1'b1, 120, 100);
    send(1'b1, 130, 100);
    @(negedge clk_in);
    check_seg("bp.hold", 110, 100, 120, 100);
    repeat (3) @(negedge clk_in);
    check("bp.hold_x1", int'(seg_x1), 120);
    seg_ready = 1'b1;
    @(negedge clk_in);
    check("bp.drain", int'(seg_valid), 0);
    send(1'b1, 140, 100);
    @(negedge clk_in);
    check_seg("bp.next", 120, 100, 140, 100);

    // small step below MIN_STEP is swallowed, anchor preserved
    send(1'b1, 50, 50);
    @(negedge clk_in);
    check_seg("step.jump", 140, 100, 50, 50);
    send(1'b1, 51, 50);
    @(negedge clk_in);
    check("step.d1", int'(seg_valid), 0);
    send(1'b1, 51, 51);
    @(negedge clk_in);
    check_seg("step.d2", 50, 50, 51, 51);

    // clamp out-of-range coordinates
    send(1'b1, 2000, 1000);
    @(negedge clk_in);
    check_seg("clamp", 51, 51, 1279, 719);

    // pen-up after four light-off samples, no tail segment
    repeat (3) send(1'b0, 7, 7);
    @(negedge clk_in);
    check("penup.still", int'(pen_down), 1);
    send(1'b0, 7, 7);
    @(negedge clk_in);
    check("penup.pen", int'(pen_down), 0);
    check("penup.noseg", int'(seg_valid), 0);

    // asynchronous reset mid-stroke discards the pending segment
    repeat (3) send(1'b1, 10, 10);
    seg_ready = 1'b0;
    send(1'b1, 300, 10);
    @(negedge clk_in);
    check_seg("pend", 10, 10, 300, 10);
    #2 rst_in = 1'b1;
    #1;
    check("arst.valid", int'(seg_valid), 0);
    check("arst.pen", int'(pen_down), 0);
    check("arst.x1", int'(seg_x1), 0);
    @(negedge clk_in);
    rst_in = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
